rr_decoder_arbiter: RTL and testbench

Round-robin arbiter that shares one 3-to-8 decoded resource among eight requesters. Selects a winner by rotating priority, holds the encoded 3-bit grant index for the owner's tenure, and drives a one-hot grant vector equal to the 3x8 decoding of that index. Sits directly in front of the 3x8 decoder datapath as its sequencing and sharing controller.

---
 rtl/rr_decoder_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter
//   Round-robin arbiter sharing one 3-to-8 decoded resource among eight
//   requesters. The owner keeps the grant until it strobes done or drops its
//   request. Every release is followed by one dead cycle (GAP) and then one
//   arbitration cycle (IDLE). The winner is chosen by searching req upward
//   from a rotating priority pointer.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a hold counter revokes a grant after HOLD_MAX cycles and
//     pulses timeout for one cycle. When undefined, timeout stays 0.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     req[7:0]     level-sensitive request vector, bit i = requester i
//     done         one-cycle release strobe from the current owner
//     grant[7:0]   one-hot decode of grant_idx while grant_valid, else 0
//     grant_idx    encoded index of the current (or last) owner
//     grant_valid  high while a grant is held
//     timeout      one-cycle pulse in the GAP cycle after a forced revoke
module rr_decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic       timeout_q;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       release_w;
  logic       expire;

  // Search order ptr, ptr+1, ..., ptr+7; 3-bit addition wraps 7 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // done and the owner dropping its request merge into one release.
  assign release_w = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q;

  // Cleared while arbitrating, so it starts at 0 on the first GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (state_q == IDLE) begin
      hold_q <= '0;
    end else if (state_q == GRANT) begin
      hold_q <= hold_q + 8'd1;
    end
  end

  // A release on the expiry cycle wins, so no timeout is flagged.
  assign expire = (state_q == GRANT) && (hold_q == HoldLast) && !release_w;
`else
  localparam logic [7:0] HoldMax8 = 8'(HOLD_MAX);

  logic unused_hold;
  assign unused_hold = ^HoldMax8;
  assign expire      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= GRANT;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (release_w || expire) begin
            state_q   <= GAP;
            ptr_q     <= idx_q + 3'd1;
            valid_q   <= 1'b0;
            timeout_q <= expire;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    grant = '0;
    if (valid_q) begin
      grant[idx_q] = 1'b1;
    end
  end

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int total;
  int bad;

  logic [7:0] exp_g[$];
  logic [2:0] exp_i[$];
  logic       exp_t[$];
  logic [7:0] obs_g[$];
  logic [2:0] obs_i[$];
  logic       obs_v[$];
  logic       obs_t[$];

  rr_decoder_arbiter #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next rising edge and queue what must be visible
  // after it; the outputs are sampled at the following falling edge.
  task automatic cycle(input logic [7:0] r, input logic d, input logic rs,
                       input logic [7:0] eg, input logic [2:0] ei, input logic et);
    req  = r;
    done = d;
    rst  = rs;
    exp_g.push_back(eg);
    exp_i.push_back(ei);
    exp_t.push_back(et);
    @(negedge clk);
    obs_g.push_back(grant);
    obs_i.push_back(grant_idx);
    obs_v.push_back(grant_valid);
    obs_t.push_back(timeout);
  endtask

  task automatic test_reset();
    logic [7:0] eg, og; logic [2:0] ei, oi; logic et, ov, ot;
    cycle(8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    cycle(8'hFF, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0);
    while (exp_g.size() != 0) begin
      eg = exp_g.pop_front(); ei = exp_i.pop_front(); et = exp_t.pop_front();
      og = obs_g.pop_front(); oi = obs_i.pop_front(); ov = obs_v.pop_front(); ot = obs_t.pop_front();
      total++; if (og !== eg) begin bad++; $display("FAIL reset grant: got %h want %h", og, eg); end
      total++; if (oi !== ei) begin bad++; $display("FAIL reset idx: got %0d want %0d", oi, ei); end
      total++; if (ov !== (eg != 8'h00)) begin bad++; $display("FAIL reset valid: got %b want %b", ov, eg != 8'h00); end
      total++; if (ot !== et) begin bad++; $display("FAIL reset timeout: got %b want %b", ot, et); end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] eg, og; logic [2:0] ei, oi; logic et, ov, ot;
    for (int k = 1; k <= 8; k++) begin
      cycle(8'hFF, 1'b1, 1'b0, 8'h00, 3'(k - 1), 1'b0);
      cycle(8'hFF, 1'b0, 1'b0, 8'h00, 3'(k - 1), 1'b0);
      cycle(8'hFF, 1'b0, 1'b0, 8'(1 << (k % 8)), 3'(k % 8), 1'b0);
    end
    while (exp_g.size() != 0) begin
      eg = exp_g.pop_front(); ei = exp_i.pop_front(); et = exp_t.pop_front();
      og = obs_g.pop_front(); oi = obs_i.pop_front(); ov = obs_v.pop_front(); ot = obs_t.pop_front();
      total++; if (og !== eg) begin bad++; $display("FAIL rotation grant: got %h want %h", og, eg); end
      total++; if (oi !== ei) begin bad++; $display("FAIL rotation idx: got %0d want %0d", oi, ei); end
      total++; if (ov !== (eg != 8'h00)) begin bad++; $display("FAIL rotation valid: got %b want %b", ov, eg != 8'h00); end
      total++; if (ot !== et) begin bad++; $display("FAIL rotation timeout: got %b want %b", ot, et); end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] eg, og; logic [2:0] ei, oi; logic et, ov, ot;
    // idx0 releases (ptr=1), idx2 wins; idx2 releases (ptr=3), req=05 -> idx0.
    cycle(8'h04, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle(8'h04, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle(8'h04, 1'b0, 1'b0, 8'h04, 3'd2, 1'b0);
    cycle(8'h05, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0);
    cycle(8'h05, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0);
    cycle(8'h05, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0);
    while (exp_g.size() != 0) begin
      eg = exp_g.pop_front(); ei = exp_i.pop_front(); et = exp_t.pop_front();
      og = obs_g.pop_front(); oi = obs_i.pop_front(); ov = obs_v.pop_front(); ot = obs_t.pop_front();
      total++; if (og !== eg) begin bad++; $display("FAIL fairness grant: got %h want %h", og, eg); end
      total++; if (oi !== ei) begin bad++; $display("FAIL fairness idx: got %0d want %0d", oi, ei); end
      total++; if (ov !== (eg != 8'h00)) begin bad++; $display("FAIL fairness valid: got %b want %b", ov, eg != 8'h00); end
      total++; if (ot !== et) begin bad++; $display("FAIL fairness timeout: got %b want %b", ot, et); end
    end
  endtask

  task automatic test_no_preempt();
    logic [7:0] eg, og; logic [2:0] ei, oi; logic et, ov, ot;
    // idx0 drops its request (ptr=1); idx5 wins and must not be preempted.
    cycle(8'h20, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle(8'h20, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle(8'h20, 1'b0, 1'b0, 8'h20, 3'd5, 1'b0);
    repeat (3) cycle(8'h21, 1'b0, 1'b0, 8'h20, 3'd5, 1'b0);
    repeat (3) cycle(8'hFF, 1'b0, 1'b0, 8'h20, 3'd5, 1'b0);
    cycle(8'hFF, 1'b1, 1'b0, 8'h00, 3'd5, 1'b0);
    cycle(8'hFF, 1'b0, 1'b0, 8'h00, 3'd5, 1'b0);
    cycle(8'hFF, 1'b0, 1'b0, 8'h40, 3'd6, 1'b0);
    while (exp_g.size() != 0) begin
      eg = exp_g.pop_front(); ei = exp_i.pop_front(); et = exp_t.pop_front();
      og = obs_g.pop_front(); oi = obs_i.pop_front(); ov = obs_v.pop_front(); ot = obs_t.pop_front();
      total++; if (og !== eg) begin bad++; $display("FAIL no_preempt grant: got %h want %h", og, eg); end
      total++; if (oi !== ei) begin bad++; $display("FAIL no_preempt idx: got %0d want %0d", oi, ei); end
      total++; if (ov !== (eg != 8'h00)) begin bad++; $display("FAIL no_preempt valid: got %b want %b", ov, eg != 8'h00); end
      total++; if (ot !== et) begin bad++; $display("FAIL no_preempt timeout: got %b want %b", ot, et); end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [7:0] eg, og; logic [2:0] ei, oi; logic et, ov, ot;
    // idx6 drops (ptr=7); idx4 wins; reset mid-grant.
    cycle(8'h10, 1'b0, 1'b0, 8'h00, 3'd6, 1'b0);
    cycle(8'h10, 1'b0, 1'b0, 8'h00, 3'd6, 1'b0);
    cycle(8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
    cycle(8'h10, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    cycle(8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
    // idx4 drops (ptr=5) so idx7 wins; reset must pull ptr back to 0,
    // making idx0 win over idx7 afterwards.
    cycle(8'h81, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0);
    cycle(8'h81, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0);
    cycle(8'h81, 1'b0, 1'b0, 8'h80, 3'd7, 1'b0);
    cycle(8'h81, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    cycle(8'h81, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0);
    while (exp_g.size() != 0) begin
      eg = exp_g.pop_front(); ei = exp_i.pop_front(); et = exp_t.pop_front();
      og = obs_g.pop_front(); oi = obs_i.pop_front(); ov = obs_v.pop_front(); ot = obs_t.pop_front();
      total++; if (og !== eg) begin bad++; $display("FAIL reset_mid grant: got %h want %h", og, eg); end
      total++; if (oi !== ei) begin bad++; $display("FAIL reset_mid idx: got %0d want %0d", oi, ei); end
      total++; if (ov !== (eg != 8'h00)) begin bad++; $display("FAIL reset_mid valid: got %b want %b", ov, eg != 8'h00); end
      total++; if (ot !== et) begin bad++; $display("FAIL reset_mid timeout: got %b want %b", ot, et); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eg, og; logic [2:0] ei, oi; logic et, ov, ot;
    // idx0 drops (ptr=1); lone requester idx3 with done held high must
    // re-acquire every third cycle (done is ignored in GAP and IDLE).
    cycle(8'h08, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle(8'h08, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    cycle(8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0);
    repeat (3) begin
      cycle(8'h08, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0);
      cycle(8'h08, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0);
      cycle(8'h08, 1'b1, 1'b0, 8'h08, 3'd3, 1'b0);
    end
    // No requests: stays idle, done has no effect (ptr ends at 4).
    repeat (4) cycle(8'h00, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0);
    while (exp_g.size() != 0) begin
      eg = exp_g.pop_front(); ei = exp_i.pop_front(); et = exp_t.pop_front();
      og = obs_g.pop_front(); oi = obs_i.pop_front(); ov = obs_v.pop_front(); ot = obs_t.pop_front();
      total++; if (og !== eg) begin bad++; $display("FAIL back_to_back grant: got %h want %h", og, eg); end
      total++; if (oi !== ei) begin bad++; $display("FAIL back_to_back idx: got %0d want %0d", oi, ei); end
      total++; if (ov !== (eg != 8'h00)) begin bad++; $display("FAIL back_to_back valid: got %b want %b", ov, eg != 8'h00); end
      total++; if (ot !== et) begin bad++; $display("FAIL back_to_back timeout: got %b want %b", ot, et); end
    end
  endtask

  task automatic test_hold();
    logic [7:0] eg, og; logic [2:0] ei, oi; logic et, ov, ot;
    // ptr=4, req=02 -> idx1 wins; first grant cycle visible here.
    cycle(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    repeat (3) cycle(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0);
    cycle(8'h02, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1);
    cycle(8'h02, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0);
    cycle(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0);
    repeat (3) cycle(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0);
    cycle(8'h02, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0);
    cycle(8'h02, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0);
`else
    repeat (20) cycle(8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0);
    cycle(8'h02, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0);
    cycle(8'h02, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0);
`endif
    while (exp_g.size() != 0) begin
      eg = exp_g.pop_front(); ei = exp_i.pop_front(); et = exp_t.pop_front();
      og = obs_g.pop_front(); oi = obs_i.pop_front(); ov = obs_v.pop_front(); ot = obs_t.pop_front();
      total++; if (og !== eg) begin bad++; $display("FAIL hold grant: got %h want %h", og, eg); end
      total++; if (oi !== ei) begin bad++; $display("FAIL hold idx: got %0d want %0d", oi, ei); end
      total++; if (ov !== (eg != 8'h00)) begin bad++; $display("FAIL hold valid: got %b want %b", ov, eg != 8'h00); end
      total++; if (ot !== et) begin bad++; $display("FAIL hold timeout: got %b want %b", ot, et); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) begin
      @(negedge clk);
    end
    test_reset();
    test_rotation();
    test_fairness();
    test_no_preempt();
    test_reset_mid_grant();
    test_back_to_back();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
